// File: rtl/can_tx_scheduler.sv
// Shares one CAN transmitter among NUM_MB mailboxes: lowest identifier wins, with retry, arbitration-loss and IFS handling.
// Optional TX_WATCHDOG_EN adds a baud-tick timeout on the transmitter handshake and a watchdog_trip pulse.
`timescale 1ns/1ps
module can_tx_scheduler #(
    parameter int NUM_MB    = 4,
    parameter int ID_W      = 11,
    parameter int DATA_W    = 64,
    parameter int MAX_RETRY = 8,
    parameter int IFS_BITS  = 3
) (
    input  logic                     clk,
    input  logic                     RESET_N,
    input  logic                     baud_clk,
    input  logic [NUM_MB-1:0]        mb_req,
    input  logic [NUM_MB*ID_W-1:0]   mb_id,
    input  logic [NUM_MB*DATA_W-1:0] mb_data,
    output logic [NUM_MB-1:0]        mb_done,
    output logic [NUM_MB-1:0]        mb_err,
    output logic [ID_W-1:0]          tx_address,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     send_data,
    input  logic                     tx_busy,
    input  logic                     tx_ok,
    input  logic                     arb_lost,
    input  logic                     tx_fail,
`ifdef TX_WATCHDOG_EN
    output logic                     watchdog_trip,
`endif
    output logic [2:0]               active_mb
);

    typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, WAIT_START, WAIT_END, IFS} state_e;

    state_e              state_q;
    logic [ID_W-1:0]     addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                send_q;
    logic [NUM_MB-1:0]   done_q;
    logic [NUM_MB-1:0]   err_q;
    logic [2:0]          active_q;
    logic [3:0]          retry_q [NUM_MB];
    logic [7:0]          ifs_q;

    logic                win_found;
    logic [2:0]          win_idx;
    logic [ID_W-1:0]     win_id;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_MB-1:0]   act_oh;
    logic [3:0]          cur_retry;
    logic [3:0]          retry_d;
    logic                retry_max;
    logic                start_to;
    logic                end_to;
    logic                fail_now;
    logic                frame_end;

    // Strict '<' keeps the lowest index on identifier ties.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_id    = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (mb_req[i] && (!win_found || (mb_id[i*ID_W +: ID_W] < win_id))) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_id    = mb_id[i*ID_W +: ID_W];
                win_data  = mb_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        act_oh    = '0;
        cur_retry = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            act_oh[i] = (active_q == 3'(i));
            if (act_oh[i]) cur_retry = retry_q[i];
        end
    end

    assign retry_d   = cur_retry + 4'd1;
    assign retry_max = (retry_d == 4'(MAX_RETRY));
    assign fail_now  = ((state_q == WAIT_START) && start_to) ||
                       ((state_q == WAIT_END) && !tx_ok && (tx_fail || end_to));
    assign frame_end = tx_ok || tx_fail || arb_lost || end_to;

`ifdef TX_WATCHDOG_EN
    logic [15:0] wd_q;
    logic        trip_q;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            wd_q   <= '0;
            trip_q <= 1'b0;
        end else begin
            trip_q <= start_to || end_to;
            if ((state_q == LAUNCH) || ((state_q == WAIT_START) && tx_busy))
                wd_q <= '0;
            else if (((state_q == WAIT_START) || (state_q == WAIT_END)) && baud_clk)
                wd_q <= wd_q + 16'd1;
        end
    end

    assign start_to = (state_q == WAIT_START) && !tx_busy && baud_clk && (wd_q == 16'd3);
    assign end_to   = (state_q == WAIT_END) && !tx_ok && !tx_fail && !arb_lost &&
                      baud_clk && (wd_q == 16'd199);
    assign watchdog_trip = trip_q;
`else
    assign start_to = 1'b0;
    assign end_to   = 1'b0;
`endif

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            send_q   <= 1'b0;
            done_q   <= '0;
            err_q    <= '0;
            active_q <= '0;
            ifs_q    <= '0;
            for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
        end else begin
            send_q <= 1'b0;
            done_q <= '0;
            err_q  <= '0;
            if (fail_now) begin
                err_q <= retry_max ? act_oh : '0;
                for (int i = 0; i < NUM_MB; i++)
                    if (act_oh[i]) retry_q[i] <= retry_max ? 4'd0 : retry_d;
            end
            case (state_q)
                IDLE: if (|mb_req) state_q <= SELECT;
                SELECT: begin
                    if (win_found) begin
                        addr_q   <= win_id;
                        data_q   <= win_data;
                        active_q <= win_idx;
                        state_q  <= LAUNCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LAUNCH: begin
                    send_q  <= 1'b1;
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (tx_busy) begin
                        state_q <= WAIT_END;
                    end else if (start_to) begin
                        ifs_q   <= '0;
                        state_q <= IFS;
                    end
                end
                WAIT_END: begin
                    if (frame_end) begin
                        ifs_q   <= '0;
                        state_q <= IFS;
                    end
                    if (tx_ok) begin
                        done_q <= act_oh;
                        for (int i = 0; i < NUM_MB; i++)
                            if (act_oh[i]) retry_q[i] <= '0;
                    end
                end
                // Foreign traffic on the bus restarts the idle count.
                IFS: begin
                    if (tx_busy) begin
                        ifs_q <= '0;
                    end else if (baud_clk) begin
                        if (ifs_q == 8'(IFS_BITS - 1)) state_q <= IDLE;
                        else                           ifs_q   <= ifs_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_address = addr_q;
    assign tx_data    = data_q;
    assign send_data  = send_q;
    assign mb_done    = done_q;
    assign mb_err     = err_q;
    assign active_mb  = active_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler: a scoreboard of expected launches/done/err pulses checked against a simple transmitter model.
`timescale 1ns/1ps
module tb_can_tx_scheduler;
    localparam int NUM_MB    = 4;
    localparam int ID_W      = 11;
    localparam int DATA_W    = 64;
    localparam int MAX_RETRY = 8;
    localparam int IFS_BITS  = 3;
    localparam int BUSY_CLKS = 6;

    typedef enum int {OUT_OK, OUT_ARB, OUT_FAIL} outcome_e;
    typedef struct {
        logic [2:0]        mb;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } send_t;

    logic                     clk = 1'b0;
    logic                     RESET_N;
    logic                     baud_clk;
    logic [NUM_MB-1:0]        mb_req;
    logic [NUM_MB*ID_W-1:0]   mb_id;
    logic [NUM_MB*DATA_W-1:0] mb_data;
    logic [NUM_MB-1:0]        mb_done;
    logic [NUM_MB-1:0]        mb_err;
    logic [ID_W-1:0]          tx_address;
    logic [DATA_W-1:0]        tx_data;
    logic                     send_data;
    logic                     tx_busy;
    logic                     tx_ok;
    logic                     arb_lost;
    logic                     tx_fail;
    logic [2:0]               active_mb;
    logic                     model_busy;
    logic                     ext_busy;
`ifdef TX_WATCHDOG_EN
    logic                     wd_trip;
`endif

    assign tx_busy = model_busy | ext_busy;

    can_tx_scheduler #(
        .NUM_MB(NUM_MB), .ID_W(ID_W), .DATA_W(DATA_W),
        .MAX_RETRY(MAX_RETRY), .IFS_BITS(IFS_BITS)
    ) dut (
        .clk(clk), .RESET_N(RESET_N), .baud_clk(baud_clk),
        .mb_req(mb_req), .mb_id(mb_id), .mb_data(mb_data),
        .mb_done(mb_done), .mb_err(mb_err),
        .tx_address(tx_address), .tx_data(tx_data), .send_data(send_data),
        .tx_busy(tx_busy), .tx_ok(tx_ok), .arb_lost(arb_lost), .tx_fail(tx_fail),
`ifdef TX_WATCHDOG_EN
        .watchdog_trip(wd_trip),
`endif
        .active_mb(active_mb)
    );

    always #5 clk = ~clk;

    send_t             exp_send_q[$];
    logic [NUM_MB-1:0] exp_done_q[$];
    logic [NUM_MB-1:0] exp_err_q[$];
    outcome_e          outcome_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, n_send = 0, n_done = 0, n_err = 0, last_send_cyc = 0;
    int m_st = 0, m_cnt = 0, bdiv = 0;
    bit ifs_arm = 1'b0;
    int ifs_bcnt = 0, b3_cyc = -1;
    int base, base_done, base_err, req_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic send_t mk(input int mb, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
        send_t s;
        s.mb = 3'(mb); s.id = id; s.data = d;
        return s;
    endfunction

    task automatic set_mb(input int i, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
        mb_id[i*ID_W +: ID_W]       = id;
        mb_data[i*DATA_W +: DATA_W] = d;
    endtask

    // One clock: reference IFS count at the edge, then monitor/scoreboard and stimulus at the falling edge.
    task automatic tick();
        send_t    e;
        outcome_e o;
        @(posedge clk);
        if (ifs_arm) begin
            if (tx_busy) ifs_bcnt = 0;
            else if (baud_clk) begin
                ifs_bcnt++;
                if (ifs_bcnt == IFS_BITS) begin b3_cyc = cyc; ifs_arm = 1'b0; end
            end
        end
        if (RESET_N && (tx_ok || tx_fail || arb_lost)) begin ifs_arm = 1'b1; ifs_bcnt = 0; b3_cyc = -1; end
        @(negedge clk);
        cyc++;
        if (send_data) begin
            n_send++;
            last_send_cyc = cyc;
            if (exp_send_q.size() == 0) check("unexpected_send", 64'(send_data), 64'd0);
            else begin
                e = exp_send_q.pop_front();
                check("send_mb", 64'(active_mb), 64'(e.mb));
                check("send_addr", 64'(tx_address), 64'(e.id));
                check("send_payload", tx_data, e.data);
            end
        end
        if (mb_done != '0) begin
            n_done++;
            if (exp_done_q.size() == 0) check("unexpected_done", 64'(mb_done), 64'd0);
            else check("done_pulse", 64'(mb_done), 64'(exp_done_q.pop_front()));
            mb_req = mb_req & ~mb_done;
        end
        if (mb_err != '0) begin
            n_err++;
            if (exp_err_q.size() == 0) check("unexpected_err", 64'(mb_err), 64'd0);
            else check("err_pulse", 64'(mb_err), 64'(exp_err_q.pop_front()));
            mb_req = mb_req & ~mb_err;
        end
        tx_ok = 1'b0; arb_lost = 1'b0; tx_fail = 1'b0;
        bdiv = (bdiv + 1) % 4;
        baud_clk = (bdiv == 0);
        if (!RESET_N) begin
            m_st = 0; model_busy = 1'b0;
        end else begin
            case (m_st)
                0: if (send_data) m_st = 1;
                1: begin model_busy = 1'b1; m_cnt = BUSY_CLKS; m_st = 2; end
                default: begin
                    if (m_cnt == 0) begin
                        o = (outcome_q.size() != 0) ? outcome_q.pop_front() : OUT_OK;
                        tx_ok    = (o == OUT_OK);
                        arb_lost = (o == OUT_ARB);
                        tx_fail  = (o == OUT_FAIL);
                        model_busy = 1'b0;
                        m_st = 0;
                    end else m_cnt--;
                end
            endcase
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (k < budget && ((exp_send_q.size() + exp_done_q.size() + exp_err_q.size() +
                               outcome_q.size()) != 0 || mb_req != '0 || m_st != 0)) begin
            tick();
            k++;
        end
        check(tag, 64'(exp_send_q.size() + exp_done_q.size() + exp_err_q.size() + outcome_q.size() + int'(mb_req)), 64'd0);
        repeat (30) tick();
    endtask

    initial begin
        RESET_N = 1'b0; mb_req = '0; mb_id = '0; mb_data = '0;
        tx_ok = 1'b0; arb_lost = 1'b0; tx_fail = 1'b0; baud_clk = 1'b0;
        model_busy = 1'b0; ext_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_send", 64'(send_data), 64'd0);
        check("rst_done", 64'(mb_done), 64'd0);
        check("rst_err", 64'(mb_err), 64'd0);
        check("rst_addr", 64'(tx_address), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_active", 64'(active_mb), 64'd0);
        RESET_N = 1'b1;
        tick(); tick();

        // Single request and launch latency.
        set_mb(0, 11'h025, 64'hA5A5_A5A5_A5A5_A5A5);
        exp_send_q.push_back(mk(0, 11'h025, 64'hA5A5_A5A5_A5A5_A5A5));
        exp_done_q.push_back(4'b0001);
        mb_req[0] = 1'b1; req_cyc = cyc;
        for (int k = 0; k < 20 && n_send < 1; k++) tick();
        check("latency", 64'(last_send_cyc - req_cyc), 64'd3);
        drain("single_drain", 300);
        check("single_done_cnt", 64'(n_done), 64'd1);

        // Priority: lowest id wins, ties by index; non-requesting mb2 has the lowest id.
        set_mb(0, 11'h100, 64'h0000_0000_0000_0100);
        set_mb(1, 11'h050, 64'h1111_1111_1111_1111);
        set_mb(2, 11'h010, 64'h2222_2222_2222_2222);
        set_mb(3, 11'h050, 64'h3333_3333_3333_3333);
        exp_send_q.push_back(mk(1, 11'h050, 64'h1111_1111_1111_1111));
        exp_send_q.push_back(mk(3, 11'h050, 64'h3333_3333_3333_3333));
        exp_send_q.push_back(mk(0, 11'h100, 64'h0000_0000_0000_0100));
        exp_done_q.push_back(4'b0010);
        exp_done_q.push_back(4'b1000);
        exp_done_q.push_back(4'b0001);
        mb_req = 4'b1011;
        drain("prio_drain", 600);
        check("prio_done_cnt", 64'(n_done), 64'd4);

        // Arbitration loss three times, then success.
        set_mb(0, 11'h025, 64'hDEAD_BEEF_0000_0025);
        for (int k = 0; k < 4; k++) exp_send_q.push_back(mk(0, 11'h025, 64'hDEAD_BEEF_0000_0025));
        for (int k = 0; k < 3; k++) outcome_q.push_back(OUT_ARB);
        outcome_q.push_back(OUT_OK);
        exp_done_q.push_back(4'b0001);
        base = n_send; base_done = n_done;
        mb_req[0] = 1'b1;
        drain("arb_drain", 800);
        check("arb_sends", 64'(n_send - base), 64'd4);
        check("arb_done_cnt", 64'(n_done - base_done), 64'd1);

        // Retry exhaustion.
        for (int k = 0; k < MAX_RETRY; k++) begin
            exp_send_q.push_back(mk(0, 11'h025, 64'hDEAD_BEEF_0000_0025));
            outcome_q.push_back(OUT_FAIL);
        end
        exp_err_q.push_back(4'b0001);
        base = n_send; base_done = n_done; base_err = n_err;
        mb_req[0] = 1'b1;
        drain("fail_drain", 1500);
        check("fail_sends", 64'(n_send - base), 64'(MAX_RETRY));
        check("fail_err_cnt", 64'(n_err - base_err), 64'd1);
        check("fail_no_done", 64'(n_done - base_done), 64'd0);

        // Arbitration losses mixed into failures do not consume retries.
        for (int k = 0; k < MAX_RETRY + 2; k++) exp_send_q.push_back(mk(0, 11'h025, 64'hDEAD_BEEF_0000_0025));
        for (int k = 0; k < MAX_RETRY - 1; k++) outcome_q.push_back(OUT_FAIL);
        outcome_q.push_back(OUT_ARB);
        outcome_q.push_back(OUT_ARB);
        outcome_q.push_back(OUT_FAIL);
        exp_err_q.push_back(4'b0001);
        base = n_send;
        mb_req[0] = 1'b1;
        drain("mix_drain", 2000);
        check("mix_sends", 64'(n_send - base), 64'(MAX_RETRY + 2));

        // Success clears the retry count.
        for (int k = 0; k < MAX_RETRY; k++) exp_send_q.push_back(mk(0, 11'h025, 64'hDEAD_BEEF_0000_0025));
        for (int k = 0; k < MAX_RETRY - 1; k++) outcome_q.push_back(OUT_FAIL);
        outcome_q.push_back(OUT_OK);
        exp_done_q.push_back(4'b0001);
        mb_req[0] = 1'b1;
        drain("clr_drain1", 1500);
        for (int k = 0; k < MAX_RETRY; k++) begin
            exp_send_q.push_back(mk(0, 11'h025, 64'hDEAD_BEEF_0000_0025));
            outcome_q.push_back(OUT_FAIL);
        end
        exp_err_q.push_back(4'b0001);
        base = n_send;
        mb_req[0] = 1'b1;
        drain("clr_drain2", 1500);
        check("clr_sends", 64'(n_send - base), 64'(MAX_RETRY));

        // Interframe spacing, including a restart caused by foreign bus traffic.
        set_mb(0, 11'h025, 64'h0000_0000_0000_00A0);
        set_mb(1, 11'h030, 64'h0000_0000_0000_00A1);
        set_mb(2, 11'h040, 64'h0000_0000_0000_00A2);
        exp_send_q.push_back(mk(0, 11'h025, 64'h0000_0000_0000_00A0));
        exp_send_q.push_back(mk(1, 11'h030, 64'h0000_0000_0000_00A1));
        exp_send_q.push_back(mk(2, 11'h040, 64'h0000_0000_0000_00A2));
        exp_done_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0010);
        exp_done_q.push_back(4'b0100);
        base = n_send;
        mb_req = 4'b0111;
        for (int k = 0; k < 300 && n_send < base + 2; k++) tick();
        check("ifs_gap", 64'(last_send_cyc), 64'(b3_cyc + 4));
        for (int k = 0; k < 300 && !(ifs_arm && ifs_bcnt == 1); k++) tick();
        check("ifs_first_tick", 64'(ifs_bcnt), 64'd1);
        ext_busy = 1'b1;
        repeat (6) tick();
        ext_busy = 1'b0;
        for (int k = 0; k < 300 && n_send < base + 3; k++) tick();
        check("ifs_restart", 64'(last_send_cyc), 64'(b3_cyc + 4));
        drain("ifs_drain", 600);

        // Reset in the middle of a frame, then re-service of the held request.
        exp_send_q.push_back(mk(0, 11'h025, 64'h0000_0000_0000_00A0));
        mb_req[0] = 1'b1;
        for (int k = 0; k < 50 && !model_busy; k++) tick();
        tick(); tick();
        check("pre_rst_addr", 64'(tx_address), 64'h025);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_send", 64'(send_data), 64'd0);
        check("mid_rst_done", 64'(mb_done), 64'd0);
        check("mid_rst_addr", 64'(tx_address), 64'd0);
        check("mid_rst_data", tx_data, 64'd0);
        check("mid_rst_active", 64'(active_mb), 64'd0);
        repeat (3) tick();
        exp_send_q.push_back(mk(0, 11'h025, 64'h0000_0000_0000_00A0));
        exp_done_q.push_back(4'b0001);
        base_done = n_done; base = n_send;
        RESET_N = 1'b1; req_cyc = cyc;
        for (int k = 0; k < 20 && n_send < base + 1; k++) tick();
        check("rst_relaunch_latency", 64'(last_send_cyc - req_cyc), 64'd3);
        drain("rst_drain", 300);
        check("rst_done_cnt", 64'(n_done - base_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Shares the single CAN transmitter (tx_container) among NUM_MB transmit mailboxes.
- Picks the pending mailbox with the numerically lowest identifier, matching CAN bus priority, and drives the transmitter's address/data/send_data inputs.
- Handles arbitration loss and error retries, and enforces interframe spacing.
- Sits between the application request logic and the CAN TX datapath; clocked by the system clk and paced by the BaudGen baud_clk tick.

Parameters:
- NUM_MB, 4, number of mailboxes (2..8).
- ID_W, 11, identifier width.
- DATA_W, 64, payload width per mailbox.
- MAX_RETRY, 8, attempts per mailbox before error is reported (1..15).
- IFS_BITS, 3, baud ticks of enforced idle between frames.

Ports:
- clk  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- baud_clk  in  1  one-clk-wide bit-time tick from BaudGen.
- mb_req  in  NUM_MB  per-mailbox level request; held until done or err.
- mb_id  in  NUM_MB*ID_W  flattened identifiers; mailbox i occupies [i*ID_W +: ID_W].
- mb_data  in  NUM_MB*DATA_W  flattened payloads, same indexing as mb_id.
- mb_done  out  NUM_MB  one-clk pulse: frame sent and acknowledged.
- mb_err  out  NUM_MB  one-clk pulse: retries exhausted.
- tx_address  out  ID_W  identifier to transmitter.
- tx_data  out  DATA_W  payload to transmitter.
- send_data  out  1  one-clk start pulse to transmitter.
- tx_busy  in  1  transmitter frame in progress.
- tx_ok  in  1  one-clk pulse: frame completed with ACK.
- arb_lost  in  1  one-clk pulse: lost arbitration.
- tx_fail  in  1  one-clk pulse: bit/ACK error.
- active_mb  out  3  index of the mailbox being served.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - All outputs 0; state IDLE; retry counters 0.
  - Takes effect mid-frame too; the transmitter is reset by the same net.
- States: IDLE, SELECT, LAUNCH, WAIT_START, WAIT_END, IFS.
- IDLE: if any mb_req bit is set, go to SELECT on the next clk.
- SELECT (1 clk):
  - Winner = lowest mb_id among requesting mailboxes; ties go to the lowest index.
  - Latch winner id/data into tx_address/tx_data and the index into active_mb.
  - If no request remains, return to IDLE.
- LAUNCH: assert send_data for exactly 1 clk, then go to WAIT_START.
- WAIT_START: wait for tx_busy=1, then go to WAIT_END.
- WAIT_END, on a completion pulse:
  - tx_ok: pulse mb_done[active_mb]; clear that retry counter; go to IFS.
  - arb_lost: no retry increment; go to IFS. The mailbox stays pending and competes again.
  - tx_fail: increment retry[active_mb]. If it reaches MAX_RETRY, pulse mb_err[active_mb] and clear the counter. Go to IFS.
  - Simultaneous pulses: priority is tx_ok, then tx_fail, then arb_lost.
- IFS: count IFS_BITS baud_clk ticks with tx_busy=0, then go to IDLE. If tx_busy rises during IFS (another node transmitting), restart the count once it falls.
- Requests:
  - Acting on the latched copy: mb_req/mb_id/mb_data are sampled only in SELECT. Later changes do not affect the frame in flight.
  - A mailbox whose mb_req drops while in flight still receives its done/err pulse.
  - A done mailbox is not reselected unless the requester still holds mb_req at the next SELECT. The requester must drop mb_req on the clk after mb_done.
- Output timing: tx_address, tx_data and active_mb are stable from SELECT until the next SELECT.
- Latency: from mb_req rising while IDLE to the send_data pulse is 3 clk.

Optional Feature:
- Macro: TX_WATCHDOG_EN.
- Defined:
  - A 16-bit baud-tick counter runs in WAIT_START and WAIT_END.
  - WAIT_START times out at 4 ticks without tx_busy; WAIT_END times out at 200 ticks.
  - A timeout is treated as tx_fail (retry accounting applies), and the output watchdog_trip pulses 1 clk.
- Undefined: no counter; watchdog_trip port absent; the FSM can wait indefinitely.

Test Plan:
- Single request: mb_req=0001, id 0x25, data 0xA5A5…; tx model asserts tx_busy 2 clk after send_data, then tx_ok → send_data 3 clk after req; tx_address=0x25; mb_done[0] pulses once.
- Priority: mb_req=1011 with ids 0x100,0x050,–,0x050 → mb1 served first (tie broken by index), then mb3, then mb0; three mb_done pulses in that order.
- Arbitration loss: mb0 id 0x25, arb_lost ×3 then tx_ok → 4 send_data pulses, retry counter stays 0, single mb_done[0].
- Error exhaustion: MAX_RETRY=8, tx_fail on every attempt → exactly 8 send_data pulses; mb_err[0] pulses once after the 8th; no mb_done.
- IFS: tx_ok then immediate second request → no send_data until 3 baud_clk ticks after tx_busy falls. Asserting tx_busy during IFS restarts the count.
- Reset mid-frame: RESET_N low in WAIT_END → all outputs 0 within the same clk; after release, a pending mb_req is re-served from SELECT.
